// File: rtl/vscpu_pkg.sv
// vscpu_pkg -- shared types and constants for very_simple_cpu.
//
// Contents:
//   DATA_W            data path width (32)
//   FIELD_W           width of the A and B instruction fields (14)
//   *_MSB / *_LSB     bit positions of the instruction fields
//                     op = [31:29], imm = [28], A = [27:14], B = [13:0]
//   opcode_e          OP_ADD .. OP_MUL
//   state_e           FETCH, LDA, LDB, EXEC, IND
//
// Build option: VSCPU_MUL_EN (see vscpu_alu / very_simple_cpu). When it is
// undefined, op 7 executes as a no-op and no multiplier is built. The normal
// product build passes +define+VSCPU_MUL_EN to the tools.

package vscpu_pkg;

   localparam int DATA_W  = 32;
   localparam int FIELD_W = 14;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 29;
   localparam int IMM_BIT = 28;
   localparam int A_MSB   = 27;
   localparam int A_LSB   = 14;
   localparam int B_MSB   = 13;
   localparam int B_LSB   = 0;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_NAND = 3'd1,
      OP_SRL  = 3'd2,
      OP_LT   = 3'd3,
      OP_CP   = 3'd4,
      OP_CPI  = 3'd5,
      OP_BZJ  = 3'd6,
      OP_MUL  = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      LDA   = 3'd1,
      LDB   = 3'd2,
      EXEC  = 3'd3,
      IND   = 3'd4
   } state_e;

endpackage

// File: rtl/vscpu_alu.sv
// vscpu_alu -- combinational result unit for very_simple_cpu.
//
// Ports:
//   op_i      opcode of the current instruction
//   imm_i     immediate flag; selects B (zero-extended) instead of *B
//   r1_i      *A
//   r2_i      *B as seen during EXEC
//   b_i       raw B field of the instruction
//   result_o  32-bit value to be written to *A
//
// Build option: VSCPU_MUL_EN enables the op 7 multiplier. When undefined the
// multiplier is not built and op 7 simply passes *A through (the top level
// also suppresses the write).

module vscpu_alu
   import vscpu_pkg::*;
(
   input  opcode_e              op_i,
   input  logic                 imm_i,
   input  logic [DATA_W-1:0]    r1_i,
   input  logic [DATA_W-1:0]    r2_i,
   input  logic [FIELD_W-1:0]   b_i,
   output logic [DATA_W-1:0]    result_o
);

   logic [DATA_W-1:0] opnd;

   always_comb begin
      opnd     = imm_i ? {{(DATA_W-FIELD_W){1'b0}}, b_i} : r2_i;
      result_o = opnd;
      case (op_i)
         OP_ADD:  result_o = r1_i + opnd;
         OP_NAND: result_o = ~(r1_i & opnd);
         OP_SRL: begin
            // Shift amounts of 32 and above turn into a left shift by s-32;
            // anything at or beyond 64 therefore yields zero.
            if (opnd < 32'd32) begin
               result_o = r1_i >> opnd[4:0];
            end else begin
               result_o = r1_i << (opnd - 32'd32);
            end
         end
         OP_LT:   result_o = {{(DATA_W-1){1'b0}}, (r1_i < opnd)};
         OP_CP:   result_o = opnd;
         OP_MUL: begin
`ifdef VSCPU_MUL_EN
            result_o = r1_i * opnd;
`else
            result_o = r1_i;
`endif
         end
         default: result_o = opnd;
      endcase
   end

endmodule

// File: rtl/very_simple_cpu.sv
// very_simple_cpu -- multi-cycle 32-bit memory-to-memory CPU.
//
// Every operand lives in one single-port RAM with a one-cycle registered
// read. Each instruction walks FETCH -> LDA -> LDB -> EXEC (4 cycles); CPI
// adds an IND cycle to finish its double indirection.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   wrEn          RAM write enable
//   addr_toRAM    RAM word address (reads and writes)
//   data_toRAM    RAM write data
//   data_fromRAM  RAM read data, valid the cycle after the address
//
// Parameter:
//   SIZE          address width in words (PC and indirect addresses are
//                 truncated to SIZE bits)
//
// Build option: VSCPU_MUL_EN enables MUL/MULi. Without it op 7 is a 4-cycle
// no-op that only advances the PC.

module very_simple_cpu
   import vscpu_pkg::*;
#(
   parameter int SIZE = 14
)
(
   input  logic                clk,
   input  logic                rst,
   output logic                wrEn,
   output logic [SIZE-1:0]     addr_toRAM,
   output logic [DATA_W-1:0]   data_toRAM,
   input  logic [DATA_W-1:0]   data_fromRAM
);

   state_e              state_q, state_d;
   logic [SIZE-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   iw_q, iw_d;
   logic [DATA_W-1:0]   r1_q, r1_d;
   logic [DATA_W-1:0]   r2_q, r2_d;

   opcode_e             op;
   logic                imm;
   logic [FIELD_W-1:0]  fld_a;
   logic [FIELD_W-1:0]  fld_b;
   logic [SIZE-1:0]     addr_a;
   logic [SIZE-1:0]     addr_b;
   logic [DATA_W-1:0]   r2_now;
   logic [DATA_W-1:0]   alu_result;

   assign op     = opcode_e'(iw_q[OP_MSB:OP_LSB]);
   assign imm    = iw_q[IMM_BIT];
   assign fld_a  = iw_q[A_MSB:A_LSB];
   assign fld_b  = iw_q[B_MSB:B_LSB];
   assign addr_a = SIZE'(fld_a);
   assign addr_b = SIZE'(fld_b);

   // *B arrives on the RAM bus during EXEC and is only latched at the end of
   // it, so EXEC must use the bus directly; other states see the stored copy.
   assign r2_now = (state_q == EXEC) ? data_fromRAM : r2_q;

   vscpu_alu u_alu (
      .op_i     (op),
      .imm_i    (imm),
      .r1_i     (r1_q),
      .r2_i     (r2_now),
      .b_i      (fld_b),
      .result_o (alu_result)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      iw_d       = iw_q;
      r1_d       = r1_q;
      r2_d       = r2_q;
      wrEn       = 1'b0;
      addr_toRAM = '0;
      data_toRAM = '0;

      case (state_q)
         FETCH: begin
            addr_toRAM = pc_q;
            state_d    = LDA;
         end

         LDA: begin
            // The instruction word is on the bus now; its A field must drive
            // the address before the word has been registered.
            iw_d       = data_fromRAM;
            addr_toRAM = SIZE'(data_fromRAM[A_MSB:A_LSB]);
            state_d    = LDB;
         end

         LDB: begin
            r1_d       = data_fromRAM;
            addr_toRAM = addr_b;
            state_d    = EXEC;
         end

         EXEC: begin
            r2_d    = data_fromRAM;
            pc_d    = pc_q + SIZE'(1);
            state_d = FETCH;
            case (op)
               OP_BZJ: begin
                  if (imm) begin
                     pc_d = SIZE'(r1_q + {{(DATA_W-FIELD_W){1'b0}}, fld_b});
                  end else if (r2_now == '0) begin
                     pc_d = SIZE'(r1_q);
                  end
               end

               OP_CPI: begin
                  if (imm) begin
                     // CPIi stores straight to mem[*A]; nothing left to read.
                     wrEn       = 1'b1;
                     addr_toRAM = SIZE'(r1_q);
                     data_toRAM = r2_now;
                  end else begin
                     // CPI still needs mem[*B]; read it and finish in IND.
                     addr_toRAM = SIZE'(r2_now);
                     state_d    = IND;
                  end
               end

               OP_MUL: begin
`ifdef VSCPU_MUL_EN
                  wrEn       = 1'b1;
                  addr_toRAM = addr_a;
                  data_toRAM = alu_result;
`endif
               end

               default: begin
                  wrEn       = 1'b1;
                  addr_toRAM = addr_a;
                  data_toRAM = alu_result;
               end
            endcase
         end

         IND: begin
            wrEn       = 1'b1;
            addr_toRAM = addr_a;
            data_toRAM = data_fromRAM;
            state_d    = FETCH;
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         pc_q    <= '0;
         iw_q    <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         iw_q    <= iw_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
      end
   end

endmodule

// File: tb/tb_very_simple_cpu.sv
// tb_very_simple_cpu -- directed bench for very_simple_cpu with a behavioural
// one-port RAM (registered read). Programs are loaded through a bench-side
// load port while rst is held low.

module tb_very_simple_cpu;

   localparam logic [2:0] ADD  = 3'd0;
   localparam logic [2:0] NAND = 3'd1;
   localparam logic [2:0] SRL  = 3'd2;
   localparam logic [2:0] LT   = 3'd3;
   localparam logic [2:0] CP   = 3'd4;
   localparam logic [2:0] CPI  = 3'd5;
   localparam logic [2:0] BZJ  = 3'd6;
   localparam logic [2:0] MUL  = 3'd7;

   logic        clk;
   logic        rst;
   logic        wrEn;
   logic [13:0] addr_toRAM;
   logic [31:0] data_toRAM;
   logic [31:0] data_fromRAM;

   logic        ld_we;
   logic [13:0] ld_addr;
   logic [31:0] ld_data;
   logic [31:0] mem [0:16383];

   int checks;
   int failures;

   very_simple_cpu #(.SIZE(14)) dut (
      .clk          (clk),
      .rst          (rst),
      .wrEn         (wrEn),
      .addr_toRAM   (addr_toRAM),
      .data_toRAM   (data_toRAM),
      .data_fromRAM (data_fromRAM)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_we) begin
         mem[ld_addr] <= ld_data;
      end else if (wrEn) begin
         mem[addr_toRAM] <= data_toRAM;
      end
      data_fromRAM <= mem[addr_toRAM];
   end

   function automatic logic [31:0] enc(input logic [2:0] op, input logic imm,
                                       input int a, input int b);
      logic [13:0] fa;
      logic [13:0] fb;
      fa = a[13:0];
      fb = b[13:0];
      return {op, imm, fa, fb};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int a, input logic [31:0] d);
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = a[13:0];
      ld_data = d;
      @(posedge clk);
      #1 ld_we = 1'b0;
   endtask

   // Releases reset on a falling edge; afterwards "cycle k" is sampled k
   // falling edges later, cycle 0 being just after the release.
   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   // Watches a halted core: no writes, and the address stays in the set a
   // BZJi A,B at PC=B produces.
   task automatic watch_halt(input string tag, input int a, input int pc);
      int wr_cnt;
      int bad_cnt;
      int pc_cnt;
      wr_cnt  = 0;
      bad_cnt = 0;
      pc_cnt  = 0;
      repeat (40) begin
         @(negedge clk);
         if (wrEn) wr_cnt++;
         if (addr_toRAM == 14'(pc)) pc_cnt++;
         else if (addr_toRAM != 14'(a) && addr_toRAM != 14'd0) bad_cnt++;
      end
      check({tag, "_no_writes"}, 32'(wr_cnt), 32'd0);
      check({tag, "_bad_addr"}, 32'(bad_cnt), 32'd0);
      check({tag, "_fetches_pc"}, 32'(pc_cnt > 0), 32'd1);
   endtask

   initial begin
      clk      = 1'b0;
      rst      = 1'b0;
      ld_we    = 1'b0;
      ld_addr  = '0;
      ld_data  = '0;
      checks   = 0;
      failures = 0;

      // ---------------- reset ----------------
      repeat (10) begin
         @(negedge clk);
         check("rst_wren", 32'(wrEn), 32'd0);
         check("rst_addr", 32'(addr_toRAM), 32'd0);
      end
      check("rst_data", data_toRAM, 32'd0);

      // ---------------- ALU program ----------------
      poke(0, enc(NAND, 0, 69, 69));
      poke(1, enc(ADD, 1, 69, 1));
      poke(2, enc(SRL, 1, 80, 3));
      poke(3, enc(SRL, 1, 81, 33));
      poke(4, enc(LT, 0, 82, 83));
      poke(5, enc(LT, 1, 84, 5));
      poke(6, enc(CP, 0, 85, 69));
      poke(7, enc(CP, 1, 86, 16383));
      poke(8, enc(ADD, 0, 88, 89));
      poke(9, enc(BZJ, 1, 87, 9));
      poke(69, 32'd1);
      poke(80, 32'h80);
      poke(81, 32'd1);
      poke(82, 32'd5);
      poke(83, 32'd7);
      poke(84, 32'd9);
      poke(85, 32'd0);
      poke(86, 32'd0);
      poke(87, 32'd0);
      poke(88, 32'hFFFF_FFF0);
      poke(89, 32'h20);
      release_rst();
      check("first_fetch_addr", 32'(addr_toRAM), 32'd0);
      check("first_fetch_wren", 32'(wrEn), 32'd0);
      repeat (3) @(negedge clk);
      check("nand_exec_wren", 32'(wrEn), 32'd1);
      check("nand_exec_addr", 32'(addr_toRAM), 32'd69);
      check("nand_exec_data", data_toRAM, 32'hFFFF_FFFE);
      @(negedge clk);
      check("second_fetch_addr", 32'(addr_toRAM), 32'd1);
      repeat (40) @(negedge clk);
      check("addi_result", mem[69], 32'hFFFF_FFFF);
      check("srli_right", mem[80], 32'h10);
      check("srli_left", mem[81], 32'd2);
      check("lt_true", mem[82], 32'd1);
      check("lti_false", mem[84], 32'd0);
      check("cp_result", mem[85], 32'hFFFF_FFFF);
      check("cpi_imm_zext", mem[86], 32'h3FFF);
      check("add_wrap", mem[88], 32'h10);
      watch_halt("alu_halt", 87, 9);

      // ---------------- branch + indirect program ----------------
      rst = 1'b0;
      poke(0, enc(BZJ, 0, 72, 71));
      poke(1, enc(CP, 1, 90, 111));
      poke(2, enc(BZJ, 0, 72, 91));
      poke(3, enc(CPI, 1, 70, 100));
      poke(4, enc(CPI, 0, 74, 70));
      poke(5, enc(CP, 1, 92, 222));
      poke(6, enc(BZJ, 0, 94, 95));
      poke(19, enc(BZJ, 1, 20, 19));
      poke(20, 32'd0);
      poke(70, 32'd1000);
      poke(71, 32'd0);
      poke(72, 32'd2);
      poke(74, 32'd0);
      poke(90, 32'hDEAD);
      poke(91, 32'd1);
      poke(92, 32'd0);
      poke(94, 32'd19);
      poke(95, 32'd0);
      poke(100, 32'd6);
      poke(1000, 32'h55);
      release_rst();
      repeat (4) @(negedge clk);
      check("bzj_taken_fetch", 32'(addr_toRAM), 32'd2);
      repeat (4) @(negedge clk);
      check("bzj_not_taken_fetch", 32'(addr_toRAM), 32'd3);
      repeat (3) @(negedge clk);
      check("cpii_exec_wren", 32'(wrEn), 32'd1);
      check("cpii_exec_addr", 32'(addr_toRAM), 32'd1000);
      check("cpii_exec_data", data_toRAM, 32'd6);
      // Abort the CPIi store mid-cycle: the write must never land.
      rst = 1'b0;
      #1;
      check("abort_wren", 32'(wrEn), 32'd0);
      check("abort_addr", 32'(addr_toRAM), 32'd0);
      @(posedge clk);
      #1;
      check("abort_no_store", mem[1000], 32'h55);
      release_rst();
      repeat (60) @(negedge clk);
      check("cpii_store", mem[1000], 32'd6);
      check("cpi_load", mem[74], 32'd6);
      check("bzj_skipped", mem[90], 32'hDEAD);
      check("after_branches", mem[92], 32'd222);
      watch_halt("bzji_halt", 20, 19);

`ifdef VSCPU_MUL_EN
      // ---------------- factorial 6! ----------------
      rst = 1'b0;
      poke(0, enc(CP, 1, 101, 1));
      poke(1, enc(CP, 1, 102, 6));
      poke(2, enc(CP, 1, 103, 1000));
      poke(3, enc(CPI, 1, 103, 102));
      poke(4, enc(ADD, 1, 103, 1));
      poke(5, enc(ADD, 0, 102, 106));
      poke(6, enc(BZJ, 0, 107, 102));
      poke(7, enc(BZJ, 1, 108, 3));
      poke(8, enc(CP, 1, 103, 1000));
      poke(9, enc(CPI, 0, 104, 103));
      poke(10, enc(BZJ, 0, 109, 104));
      poke(11, enc(MUL, 0, 101, 104));
      poke(12, enc(ADD, 1, 103, 1));
      poke(13, enc(BZJ, 1, 108, 9));
      poke(14, enc(BZJ, 1, 108, 14));
      poke(106, 32'hFFFF_FFFF);
      poke(107, 32'd8);
      poke(108, 32'd0);
      poke(109, 32'd14);
      poke(1006, 32'd0);
      release_rst();
      repeat (600) @(negedge clk);
      check("fact_result", mem[101], 32'd720);
      check("fact_countdown_first", mem[1000], 32'd6);
      check("fact_countdown_last", mem[1005], 32'd1);
`endif

      // ---------------- op 7 ----------------
      rst = 1'b0;
      poke(0, enc(MUL, 0, 76, 74));
      poke(1, enc(CP, 1, 77, 5));
      poke(2, enc(BZJ, 1, 108, 2));
      poke(74, 32'd6);
      poke(76, 32'd7);
      poke(77, 32'd0);
      poke(108, 32'd0);
      release_rst();
      repeat (3) @(negedge clk);
`ifdef VSCPU_MUL_EN
      check("mul_exec_wren", 32'(wrEn), 32'd1);
      check("mul_exec_data", data_toRAM, 32'd42);
`else
      check("mul_exec_wren", 32'(wrEn), 32'd0);
`endif
      @(negedge clk);
      check("mul_next_fetch", 32'(addr_toRAM), 32'd1);
      repeat (20) @(negedge clk);
`ifdef VSCPU_MUL_EN
      check("mul_result", mem[76], 32'd42);
`else
      check("mul_noop_result", mem[76], 32'd7);
`endif
      check("after_mul", mem[77], 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
